ps2_keycode: RTL and testbench
==============================

PS2_KEYCODE -- requirements
Module: ps2_keycode

Interface
REQ-001 Parameter TIMEOUT, default 50000, is the number of clk cycles with no ps2_clk falling edge after which a partial frame is abandoned.
REQ-002 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ps2_clk  input  1  PS/2 device clock; asynchronous to clk.
REQ-005 ps2_data  input  1  PS/2 device data; asynchronous to clk.
REQ-006 key_code  output  8  scan code of the currently held key; 8'h00 when no key is held; drives the two-digit hex display stage, which blanks on 8'h00.
REQ-007 key_ext  output  1  held key was prefixed by E0; 0 when key_code is 8'h00.
REQ-008 key_count  output  8  binary count of distinct key presses.
REQ-009 byte_valid  output  1  one-cycle pulse per good received byte.
REQ-010 rx_byte  output  8  last good received byte; stable until the next good byte.
REQ-011 frame_err  output  1  one-cycle pulse per rejected or abandoned frame.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected from the synchronized ps2_clk and a third registered copy.
REQ-013 On each detected falling edge, the synchronized ps2_data SHALL be shifted in; bit index 0 to 10 increments; frame = start(0), D0..D7 LSB first, odd parity, stop(1).
REQ-014 At the 11th edge (cycle N): if start==0, stop==1 and odd parity over D0..D7+P holds, then rx_byte<=data and byte_valid=1 in cycle N+1; otherwise frame_err=1 in N+1 and the byte is discarded. Bit index returns to 0 in either case.
REQ-015 An idle counter SHALL clear on every falling edge; if bit index is nonzero and the counter reaches TIMEOUT, bit index SHALL return to 0 and frame_err SHALL pulse once. There is no timeout when the bit index is 0.
REQ-016 Decoder FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and advance only on byte_valid; frame errors SHALL leave the state unchanged.
REQ-017 Transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte is a final code X: make from IDLE/EXT, break from BRK/EXT_BRK; final code returns to IDLE.
REQ-018 Make X with ext flag e: if X==key_code and e==key_ext (typematic repeat), no change; otherwise key_code<=X, key_ext<=e, key_count<=key_count+1.
REQ-019 Break X with ext flag e: if X==key_code and e==key_ext, key_code<=8'h00 and key_ext<=0; otherwise, no output change.
REQ-020 E0 or F0 received in EXT/BRK/EXT_BRK (other than EXT+F0) SHALL be treated as in IDLE (restart prefix).
REQ-021 key_code, key_ext and key_count SHALL update in cycle N+2 relative to the stop-bit edge (one cycle after byte_valid).
REQ-022 key_count SHALL wrap 8'hFF->8'h00.
REQ-023 A make code of 8'h00 SHALL be ignored (no count, no key_code change).

Reset
REQ-024 While rst=1: key_code=8'h00, key_ext=0, key_count=8'h00, byte_valid=0, rx_byte=8'h00, frame_err=0, FSM=IDLE, bit index=0, idle counter=0, synchronizers=1.
REQ-025 rst asserted mid-frame SHALL discard the partial frame with no frame_err; the first frame after release is received normally.

Verification
REQ-026 Frame 8'h1C, parity 0 -> byte_valid pulse, rx_byte=8'h1C, key_code=8'h1C, key_ext=0, key_count=1.
REQ-027 1C,1C,1C,F0,1C -> key_count stays 1 through repeats; key_code=8'h00 after F0 1C.
REQ-028 1C then frame 8'h32 with parity bit forced to 1 -> frame_err one pulse, no byte_valid, key_code=8'h1C, count unchanged.
REQ-029 E0,75 then E0,F0,75 -> key_code=8'h75, key_ext=1, count+1; then key_code=8'h00, key_ext=0.
REQ-030 Four bits of a frame, then ps2_clk held high for TIMEOUT cycles -> single frame_err; next full frame 8'h1C is accepted.
REQ-031 256 distinct make/break pairs from count 0 -> key_count wraps to 8'h00; rst pulsed mid-frame -> all outputs at reset values, no frame_err.

Source files
------------

// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver and scan-code decoder.
// Receives 11-bit PS/2 frames, validates start/parity/stop, and tracks the
// currently held key (with E0 extension flag) plus a count of distinct presses.
//
// Decoder states:
//   state   | meaning
//   IDLE    | no prefix pending; next plain byte is a make code
//   EXT     | E0 received; next plain byte is an extended make
//   BRK     | F0 received; next plain byte is a break
//   EXT_BRK | E0 F0 received; next plain byte is an extended break
module ps2_keycode #(
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic [7:0] key_count,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   logic          clk_s1_q, clk_s2_q, clk_s3_q;
   logic          dat_s1_q, dat_s2_q;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          byte_valid_q, byte_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   state_t        state_q, state_d;
   logic [7:0]    key_code_q, key_code_d;
   logic          key_ext_q, key_ext_d;
   logic [7:0]    key_count_q, key_count_d;

   logic          ps2_fall;
   logic [10:0]   frame;

   // Synchronizers idle high so reset release never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         clk_s3_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         clk_s3_q <= clk_s2_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   assign ps2_fall = clk_s3_q & ~clk_s2_q;
   // Bit 10 (stop) is taken live on the last edge; bits 0..9 are already shifted in.
   assign frame    = {dat_s2_q, shift_q};

   // Frame receiver: shift on falling edges, validate on the 11th, abandon on idle timeout.
   always_comb begin
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      idle_cnt_d   = idle_cnt_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (ps2_fall) begin
         idle_cnt_d = '0;
         if (bit_idx_q == 4'd10) begin
            bit_idx_d = 4'd0;
            if (!frame[0] && frame[10] && (^frame[9:1])) begin
               byte_valid_d = 1'b1;
               rx_byte_d    = frame[8:1];
            end else begin
               frame_err_d = 1'b1;
            end
         end else begin
            shift_d   = {dat_s2_q, shift_q[9:1]};
            bit_idx_d = bit_idx_q + 4'd1;
         end
      end else if (bit_idx_q != 4'd0) begin
         if (idle_cnt_q == CW'(TIMEOUT)) begin
            bit_idx_d   = 4'd0;
            idle_cnt_d  = '0;
            frame_err_d = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
         end
      end
   end

   // Receiver registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q      <= '0;
         bit_idx_q    <= 4'd0;
         idle_cnt_q   <= '0;
         rx_byte_q    <= 8'h00;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         idle_cnt_q   <= idle_cnt_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // Decoder: prefix tracking and held-key bookkeeping, advancing only on good bytes.
   always_comb begin
      logic is_ext;
      logic is_brk;
      logic match;
      state_d     = state_q;
      key_code_d  = key_code_q;
      key_ext_d   = key_ext_q;
      key_count_d = key_count_q;
      is_ext      = (state_q == EXT) || (state_q == EXT_BRK);
      is_brk      = (state_q == BRK) || (state_q == EXT_BRK);
      match       = (rx_byte_q == key_code_q) && (is_ext == key_ext_q);
      if (byte_valid_q) begin
         if (rx_byte_q == 8'hE0) begin
            state_d = EXT;
         end else if (rx_byte_q == 8'hF0) begin
            state_d = (state_q == EXT) ? EXT_BRK : BRK;
         end else begin
            state_d = IDLE;
            if (is_brk) begin
               if (match) begin
                  key_code_d = 8'h00;
                  key_ext_d  = 1'b0;
               end
            end else if ((rx_byte_q != 8'h00) && !match) begin
               key_code_d  = rx_byte_q;
               key_ext_d   = is_ext;
               key_count_d = key_count_q + 8'd1;
            end
         end
      end
   end

   // Decoder registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         key_code_q  <= 8'h00;
         key_ext_q   <= 1'b0;
         key_count_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         key_code_q  <= key_code_d;
         key_ext_q   <= key_ext_d;
         key_count_q <= key_count_d;
      end
   end

   assign key_code   = key_code_q;
   assign key_ext    = key_ext_q;
   assign key_count  = key_count_q;
   assign byte_valid = byte_valid_q;
   assign rx_byte    = rx_byte_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Directed bench for ps2_keycode: expected received bytes are queued as frames
// are sent and popped when byte_valid fires; key state is checked after each step.
module tb_ps2_keycode;

   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_code;
   logic       key_ext;
   logic [7:0] key_count;
   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       frame_err;

   int         n_checks = 0;
   int         n_err = 0;
   int         bv_cnt = 0;
   int         fe_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   ps2_keycode #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_code(key_code), .key_ext(key_ext), .key_count(key_count),
      .byte_valid(byte_valid), .rx_byte(rx_byte), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: pop the expected byte whenever the DUT reports one.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_err) fe_cnt++;
         if (byte_valid) begin
            bv_cnt++;
            if (exp_q.size() == 0) begin
               check("byte_expected", 8'(exp_q.size()), 8'd1);
            end else begin
               exp_b = exp_q.pop_front();
               check("rx_byte", rx_byte, exp_b);
            end
         end
      end
   end

   function automatic logic [10:0] mk(input logic [7:0] d, input logic bad);
      return {1'b1, (~^d) ^ bad, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = b[i];
         repeat (2) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (2) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] d);
      exp_q.push_back(d);
      send_bits(mk(d, 1'b0), 11);
      repeat (4) @(negedge clk);
   endtask

   task automatic send_bad(input logic [7:0] d);
      send_bits(mk(d, 1'b1), 11);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_key(input string tag, input logic [7:0] code, input logic ext,
                            input logic [7:0] cnt);
      check({tag, "_code"}, key_code, code);
      check({tag, "_ext"}, 8'(key_ext), 8'(ext));
      check({tag, "_count"}, key_count, cnt);
   endtask

   task automatic check_reset(input string tag);
      check_key(tag, 8'h00, 1'b0, 8'h00);
      check({tag, "_bv"}, 8'(byte_valid), 8'd0);
      check({tag, "_rx"}, rx_byte, 8'h00);
      check({tag, "_fe"}, 8'(frame_err), 8'd0);
   endtask

   initial begin
      logic [10:0] b;
      logic [7:0]  c;
      int          fe0;
      int          bv0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // First frame with exact latency: byte_valid in N+1, key state in N+2.
      b = mk(8'h1C, 1'b0);
      exp_q.push_back(8'h1C);
      send_bits(b, 10);
      ps2_data = b[10];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      check("bv_early", 8'(byte_valid), 8'd0);
      @(negedge clk);
      check("bv_n1", 8'(byte_valid), 8'd1);
      check("code_n1", key_code, 8'h00);
      @(negedge clk);
      check("bv_pulse", 8'(byte_valid), 8'd0);
      check("code_n2", key_code, 8'h1C);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
      check_key("first", 8'h1C, 1'b0, 8'd1);

      // Typematic repeats then break.
      send(8'h1C);
      send(8'h1C);
      check_key("repeat", 8'h1C, 1'b0, 8'd1);
      send(8'hF0);
      send(8'h1C);
      check_key("break", 8'h00, 1'b0, 8'd1);

      // Bad parity frame is rejected.
      send(8'h1C);
      fe0 = fe_cnt;
      bv0 = bv_cnt;
      send_bad(8'h32);
      check("parity_fe", 8'(fe_cnt - fe0), 8'd1);
      check("parity_bv", 8'(bv_cnt - bv0), 8'd0);
      check("parity_rx", rx_byte, 8'h1C);
      check_key("parity", 8'h1C, 1'b0, 8'd2);

      // Extended make, mismatched plain break, extended break.
      send(8'hE0);
      send(8'h75);
      check_key("ext_make", 8'h75, 1'b1, 8'd3);
      send(8'hF0);
      send(8'h75);
      check_key("plain_brk", 8'h75, 1'b1, 8'd3);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      check_key("ext_brk", 8'h00, 1'b0, 8'd3);

      // Make 00 is ignored; prefix restart F0 E0 gives an extended make.
      send(8'h00);
      check_key("make00", 8'h00, 1'b0, 8'd3);
      send(8'hF0);
      send(8'hE0);
      send(8'h6B);
      check_key("restart", 8'h6B, 1'b1, 8'd4);
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      check_key("restart_brk", 8'h00, 1'b0, 8'd4);

      // Partial frame abandoned by timeout, exactly one error, then recovery.
      fe0 = fe_cnt;
      bv0 = bv_cnt;
      send_bits(mk(8'h1C, 1'b0), 4);
      repeat (TO + 10) @(negedge clk);
      check("timeout_fe", 8'(fe_cnt - fe0), 8'd1);
      repeat (2 * TO) @(negedge clk);
      check("timeout_once", 8'(fe_cnt - fe0), 8'd1);
      check("timeout_bv", 8'(bv_cnt - bv0), 8'd0);
      send(8'h1C);
      check_key("after_to", 8'h1C, 1'b0, 8'd5);

      // Count wrap over 256 make/break pairs from zero.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset("reset2");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         c = 8'(i[6:0]) + 8'd1;
         send(c);
         send(8'hF0);
         send(c);
         if (i == 254) check("count_ff", key_count, 8'hFF);
      end
      check_key("wrap", 8'h00, 1'b0, 8'h00);

      // Reset mid-frame: no frame error, next frame received normally.
      send(8'h1C);
      check_key("pre_rst", 8'h1C, 1'b0, 8'd1);
      fe0 = fe_cnt;
      send_bits(mk(8'h32, 1'b0), 5);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("mid_rst");
      rst = 1'b0;
      repeat (2 * TO) @(negedge clk);
      check("mid_rst_fe", 8'(fe_cnt - fe0), 8'd0);
      send(8'h1C);
      check_key("post_rst", 8'h1C, 1'b0, 8'd1);

      check("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
